// File: rtl/display_scanner_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] ANODE_OFF = 4'hF;

endpackage

// File: rtl/display_scanner_if.sv
// Digit inputs, blink controls and display pin outputs of the display scanner.
interface display_scanner_if;
  logic       enable;
  logic [3:0] sec_units;
  logic [2:0] sec_tens;
  logic [3:0] min_units;
  logic [2:0] min_tens;
  logic [3:0] blink_mask;
  logic       dp_enable;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output enable, sec_units, sec_tens, min_units, min_tens, blink_mask, dp_enable,
    input  anode, seg, dp
  );

  modport slave (
    input  enable, sec_units, sec_tens, min_units, min_tens, blink_mask, dp_enable,
    output anode, seg, dp
  );
endinterface

// File: rtl/display_scanner_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; 10-15 decode to blank.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit common-anode display scanner with frame snapshot,
// per-digit blink blanking and a blinking separator dot on digit 2.
module display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 500
) (
  input  logic              clk,
  input  logic              reset,
  display_scanner_if.slave  bus
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BC_W  = $clog2(BLINK_TICKS + 1);

  logic [PRE_W-1:0]  pre, pre_n;
  digit_idx_t        idx, idx_n;
  logic [BC_W-1:0]   bc, bc_n;
  logic              phase, phase_n;
  logic              fresh, fresh_n;
  logic [3:0][3:0]   snap, snap_n;

  logic              tick, bc_wrap, load, blank;
  logic [6:0]        dec_seg;
  logic [3:0]        anode_p0, anode_p1;
  logic [6:0]        seg_p0, seg_p1;
  logic              dp_p0, dp_p1;

  always_comb begin
    tick    = bus.enable && (pre == PRE_W'(REFRESH_DIV - 1));
    bc_wrap = tick && (bc == BC_W'(BLINK_TICKS - 1));
    // Snapshot refresh at frame wrap, or once on the first enabled cycle after reset.
    load    = bus.enable && (fresh || (tick && idx == 2'd3));

    pre_n   = pre;
    idx_n   = idx;
    bc_n    = bc;
    phase_n = phase;
    fresh_n = fresh;
    snap_n  = snap;

    if (bus.enable) pre_n = tick ? '0 : pre + PRE_W'(1);
    if (tick) begin
      idx_n = idx + 2'd1;
      bc_n  = bc_wrap ? '0 : bc + BC_W'(1);
    end
    if (bc_wrap) phase_n = ~phase;
    if (load) begin
      snap_n  = {1'b0, bus.min_tens, bus.min_units, 1'b0, bus.sec_tens, bus.sec_units};
      fresh_n = 1'b0;
    end
  end

  bcd_to_seg u_dec (
    .bcd (snap_n[idx_n]),
    .seg (dec_seg)
  );

  // Output stage p0: drive from next-state so pins move on the same edge as idx.
  always_comb begin
    blank    = bus.blink_mask[idx_n] && phase_n;
    anode_p0 = ANODE_OFF;
    seg_p0   = SEG_BLANK;
    dp_p0    = 1'b1;
    if (bus.enable && !blank) begin
      anode_p0 = ~(4'b0001 << idx_n);
      seg_p0   = dec_seg;
      dp_p0    = !(idx_n == 2'd2 && bus.dp_enable && !phase_n);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre      <= '0;
      idx      <= '0;
      bc       <= '0;
      phase    <= 1'b0;
      fresh    <= 1'b1;
      snap     <= '0;
      anode_p1 <= ANODE_OFF;
      seg_p1   <= SEG_BLANK;
      dp_p1    <= 1'b1;
    end else begin
      pre      <= pre_n;
      idx      <= idx_n;
      bc       <= bc_n;
      phase    <= phase_n;
      fresh    <= fresh_n;
      snap     <= snap_n;
      anode_p1 <= anode_p0;
      seg_p1   <= seg_p0;
      dp_p1    <= dp_p0;
    end
  end

  // Output stage p1: registered display pins.
  assign bus.anode = anode_p1;
  assign bus.seg   = seg_p1;
  assign bus.dp    = dp_p1;

endmodule
